regfile_wb_ctrl: RTL and testbench

- Initiator side of the register-file write port: drives we3/a3/wd3 into regfile.
- Merges the single-cycle ALU writeback stream with a handshaked long-latency writeback stream (load/mul/div).
- Long-latency results are buffered in a small FIFO and drained into free write slots.
- Exports a per-register busy vector so decode can stall on pending writes.

---
 rtl/rv_pkg.sv | 11 +
 rtl/wb_fifo.sv | 59 +++++
 rtl/regfile_wb_ctrl.sv | 88 ++++++++
 tb/tb_regfile_wb_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared register-writeback types for the regfile write-port controller.
package rv_pkg;
    localparam int XLEN     = 32;
    localparam int AW       = 5;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// Small FIFO of pending long-latency writebacks; exposes every slot so the
// owner can compute per-register busy bits.
module wb_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  wb_req_t                push_req,
    input  logic                   pop,
    output wb_req_t                head,
    output logic [CW-1:0]          count,
    output logic [DEPTH-1:0]       slot_vld,
    output wb_req_t [DEPTH-1:0]    slots
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [PW-1:0] wr_ptr, rd_ptr;
    wb_req_t [DEPTH-1:0] mem;
    logic do_push, do_pop;

    // Occupancy decides full/empty; pointers just wrap on the power-of-two depth.
    assign do_push = push && (count != FULL);
    assign do_pop  = pop && (count != '0);

    assign head  = mem[rd_ptr];
    assign slots = mem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            slot_vld <= '0;
        end else begin
            if (do_push) begin
                wr_ptr           <= wr_ptr + 1'b1;
                slot_vld[wr_ptr] <= 1'b1;
            end
            if (do_pop) begin
                rd_ptr           <= rd_ptr + 1'b1;
                slot_vld[rd_ptr] <= 1'b0;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_req;
    end
endmodule

// File: rtl/regfile_wb_ctrl.sv
// Regfile write-port initiator: ALU results take priority, buffered
// long-latency results drain into free slots, busy vector tracks pending writes.
module regfile_wb_ctrl
    import rv_pkg::wb_req_t;
#(
    parameter int XLEN  = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      alu_valid,
    input  logic [AW-1:0]             alu_rd,
    input  logic [XLEN-1:0]           alu_data,
    input  logic                      sec_valid,
    output logic                      sec_ready,
    input  logic [AW-1:0]             sec_rd,
    input  logic [XLEN-1:0]           sec_data,
    output logic                      we3,
    output logic [AW-1:0]             a3,
    output logic [XLEN-1:0]           wd3,
    output logic [31:0]               busy,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic                      hazard_err
);
    localparam int CW = $clog2(DEPTH) + 1;

    wb_req_t               head;
    wb_req_t [DEPTH-1:0]   slots;
    logic    [DEPTH-1:0]   slot_vld;
    logic alu_take, fifo_empty, push, pop, hazard_hit;

    assign alu_take   = alu_valid && (alu_rd != '0);
    assign fifo_empty = (fifo_count == '0);
    assign sec_ready  = (fifo_count != CW'(DEPTH));
    // rd=0 results complete the handshake but are dropped here.
    assign push       = sec_valid && sec_ready && (sec_rd != '0);
    assign pop        = !alu_take && !fifo_empty;

    wb_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_req ('{rd: sec_rd, data: sec_data}),
        .pop      (pop),
        .head     (head),
        .count    (fifo_count),
        .slot_vld (slot_vld),
        .slots    (slots)
    );

    always_comb begin
        hazard_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (slot_vld[i] && (slots[i].rd == alu_rd)) hazard_hit = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we3        <= 1'b0;
            a3         <= '0;
            wd3        <= '0;
            hazard_err <= 1'b0;
        end else begin
            hazard_err <= alu_take && hazard_hit;
            if (alu_take) begin
                we3 <= 1'b1;
                a3  <= alu_rd;
                wd3 <= alu_data;
            end else if (!fifo_empty) begin
                we3 <= 1'b1;
                a3  <= head.rd;
                wd3 <= head.data;
            end else begin
                we3 <= 1'b0;
            end
        end
    end

    // Pending = queued in the FIFO or sitting in the output stage.
    always_comb begin
        busy = '0;
        for (int i = 0; i < DEPTH; i++)
            if (slot_vld[i]) busy[slots[i].rd] = 1'b1;
        if (we3) busy[a3] = 1'b1;
        busy[0] = 1'b0;
    end
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: queue-based reference model checked
// every cycle, plus literal expectations at the interesting points.
module tb_regfile_wb_ctrl;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid = 1'b0, sec_valid = 1'b0;
    logic [4:0]  alu_rd = '0, sec_rd = '0;
    logic [31:0] alu_data = '0, sec_data = '0;
    logic        sec_ready, we3, hazard_err;
    logic [4:0]  a3;
    logic [31:0] wd3, busy;
    logic [2:0]  fifo_count;

    regfile_wb_ctrl #(.XLEN(32), .AW(5), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .sec_valid(sec_valid), .sec_ready(sec_ready), .sec_rd(sec_rd), .sec_data(sec_data),
        .we3(we3), .a3(a3), .wd3(wd3), .busy(busy),
        .fifo_count(fifo_count), .hazard_err(hazard_err)
    );

    always #5 clk = ~clk;

    // Regfile fed from the DUT write port; x0 is not special-cased here.
    logic [31:0] tb_rf [32];
    initial for (int i = 0; i < 32; i++) tb_rf[i] = '0;
    always @(posedge clk) if (we3) tb_rf[a3] <= wd3;

    typedef struct { int rd; int unsigned data; } ent_t;
    ent_t q[$];
    logic        m_we = 1'b0, m_hz = 1'b0;
    int          m_a = 0;
    int unsigned m_wd = 0;
    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] b = '0;
        foreach (q[i]) b[q[i].rd] = 1'b1;
        if (m_we) b[m_a] = 1'b1;
        b[0] = 1'b0;
        return b;
    endfunction

    task automatic model_reset();
        q.delete();
        m_we = 1'b0; m_a = 0; m_wd = 0; m_hz = 1'b0;
    endtask

    // One clock of the writeback rules, using the inputs present at the edge.
    task automatic model_step();
        bit ready = (q.size() < DEPTH);
        bit alu_w = alu_valid && (alu_rd != 0);
        m_hz = 1'b0;
        if (alu_w) foreach (q[i]) if (q[i].rd == int'(alu_rd)) m_hz = 1'b1;
        if (alu_w) begin
            m_we = 1'b1; m_a = alu_rd; m_wd = alu_data;
        end else if (q.size() > 0) begin
            ent_t e = q.pop_front();
            m_we = 1'b1; m_a = e.rd; m_wd = e.data;
        end else begin
            m_we = 1'b0;
        end
        if (sec_valid && ready && sec_rd != 0) q.push_back('{int'(sec_rd), sec_data});
    endtask

    always @(negedge clk) begin
        chk("we3", we3, m_we);
        chk("a3", a3, m_a);
        chk("wd3", wd3, m_wd);
        chk("fifo_count", fifo_count, q.size());
        chk("sec_ready", sec_ready, q.size() < DEPTH);
        chk("busy", busy, model_busy());
        chk("hazard_err", hazard_err, m_hz);
    end

    task automatic cyc(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic sv, input logic [4:0] srd, input logic [31:0] sd);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        sec_valid = sv; sec_rd = srd; sec_data = sd;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_we3", we3, 1'b0);
        chk("reset_count", fifo_count, 0);
        chk("reset_busy", busy, 0);
        rst_n = 1'b1;
        idle();
        chk("ready_after_reset", sec_ready, 1'b1);

        // ALU write appears next cycle and clears busy after commit.
        cyc(1, 1, 100, 0, 0, 0);
        chk("t1_we3", we3, 1'b1);
        chk("t1_a3", a3, 1);
        chk("t1_wd3", wd3, 100);
        chk("t1_busy1", busy[1], 1'b1);
        idle();
        chk("t1_x1", tb_rf[1], 100);
        chk("t1_busy1_clr", busy[1], 1'b0);

        // Single secondary result drains on the following cycle.
        cyc(0, 0, 0, 1, 2, 200);
        chk("t2_count", fifo_count, 1);
        chk("t2_model_count", q.size(), 1);
        idle();
        chk("t2_a3", a3, 2);
        chk("t2_wd3", wd3, 200);
        chk("t2_count0", fifo_count, 0);

        // Fill the FIFO while the ALU owns every slot.
        for (int k = 0; k < 4; k++) cyc(1, 7, 70 + k, 1, 5'(3 + k), 100 * (3 + k));
        chk("t3_count", fifo_count, 4);
        chk("t3_ready", sec_ready, 1'b0);
        chk("t3_busy", busy[6:3], 4'b1111);
        chk("t3_a3_alu", a3, 7);
        // Full with a pop: offer is refused this cycle, taken next cycle.
        cyc(0, 0, 0, 1, 9, 900);
        chk("t3_drain3", a3, 3);
        chk("t3_count_fullpop", fifo_count, 3);
        chk("t3_ready_again", sec_ready, 1'b1);
        cyc(0, 0, 0, 1, 9, 900);
        chk("t3_drain4", a3, 4);
        chk("t3_count_pushpop", fifo_count, 3);
        idle(); chk("t3_drain5", a3, 5);
        idle(); chk("t3_drain6", a3, 6);
        idle(); chk("t3_drain9", a3, 9); chk("t3_wd9", wd3, 900);
        idle();
        chk("t3_x3", tb_rf[3], 300);
        chk("t3_x6", tb_rf[6], 600);
        chk("t3_x9", tb_rf[9], 900);

        // x0 writes from both sources vanish; secondary handshake still completes.
        chk("t4_ready", sec_ready, 1'b1);
        cyc(1, 0, 999, 1, 0, 555);
        chk("t4_we3", we3, 1'b0);
        chk("t4_count", fifo_count, 0);
        idle();
        chk("t4_x0", tb_rf[0], 0);

        // Ordering violation: flag it, let ALU write, FIFO value wins later.
        cyc(0, 0, 0, 1, 8, 32'h88);
        cyc(1, 8, 1, 0, 0, 0);
        chk("t5_hazard", hazard_err, 1'b1);
        chk("t5_wd_alu", wd3, 1);
        idle();
        chk("t5_hazard_pulse", hazard_err, 1'b0);
        chk("t5_wd_sec", wd3, 32'h88);
        idle();
        chk("t5_x8", tb_rf[8], 32'h88);

        // Reset mid-drain discards queued entries.
        for (int k = 0; k < 3; k++) cyc(1, 13, 1300, 1, 5'(10 + k), 1000 + k);
        chk("t6_count3", fifo_count, 3);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_we3", we3, 1'b0);
        chk("t6_count", fifo_count, 0);
        chk("t6_busy", busy, 0);
        alu_valid = 0; sec_valid = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) idle();
        chk("t6_no_stale", tb_rf[10], 0);
        chk("t6_busy_after", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
